fifo_unpack_256to16: RTL



---
 rtl/fifo_unpack_256to16.sv | 114 +++++++++++
 1 files changed

// File: rtl/fifo_unpack_256to16.sv
// Read-side unpacker: pulls wide words from a FIFO with no output register and
// serialises each into RATIO narrow beats on a valid/ready stream, double-buffered.
module fifo_unpack_256to16 #(
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned OUT_WIDTH = 16,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 fifo_rd_en,
  input  logic [IN_WIDTH-1:0]  fifo_rd_data,
  input  logic                 fifo_rd_empty,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic                 underrun,
  output logic                 busy
);

  // IN_WIDTH must be an integer multiple of OUT_WIDTH.
  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [IN_WIDTH-1:0] r_cur_word, r_nxt_word;
  logic                r_cur_v, r_nxt_v;
  logic                r_pend, r_flush_drop;
  logic                r_started, r_underrun;
  logic [IDX_W-1:0]    r_beat_idx;

  logic [IN_WIDTH-1:0] w_cur_word_d, w_nxt_word_d;
  logic                w_cur_v_d, w_nxt_v_d;
  logic [IDX_W-1:0]    w_beat_idx_d;
  logic                w_fire, w_last, w_take;
  logic [1:0]          w_slots;
  logic [IDX_W-1:0]    w_sel;
  logic [RATIO-1:0][OUT_WIDTH-1:0] w_beats;

  assign w_fire = r_cur_v & out_ready;
  assign w_last = w_fire & (r_beat_idx == LAST_IDX);
  // A cur slot emptied by this cycle's last beat counts as free for issue.
  assign w_slots = 2'(r_cur_v & ~w_last) + 2'(r_nxt_v) + 2'(r_pend);
  assign fifo_rd_en = ~rst & ~flush & ~fifo_rd_empty & (w_slots < 2'd2);
  assign w_take = r_pend & ~r_flush_drop;

  assign w_beats   = r_cur_word;
  assign w_sel     = LSB_FIRST ? r_beat_idx : (LAST_IDX - r_beat_idx);
  assign out_data  = w_beats[w_sel];
  assign out_valid = r_cur_v;
  assign underrun  = r_underrun;
  assign busy      = r_cur_v | r_nxt_v | r_pend;

  always_comb begin
    w_cur_word_d = r_cur_word;
    w_nxt_word_d = r_nxt_word;
    w_cur_v_d    = r_cur_v;
    w_nxt_v_d    = r_nxt_v;
    w_beat_idx_d = r_beat_idx;
    if (flush) begin
      w_cur_v_d    = 1'b0;
      w_nxt_v_d    = 1'b0;
      w_beat_idx_d = '0;
    end else begin
      if (w_fire) begin
        w_beat_idx_d = w_last ? '0 : r_beat_idx + 1'b1;
      end
      if (!r_cur_v || w_last) begin
        if (r_nxt_v) begin
          // Promote prefetched word; a returning read refills nxt directly.
          w_cur_word_d = r_nxt_word;
          w_cur_v_d    = 1'b1;
          w_nxt_v_d    = w_take;
          if (w_take) begin
            w_nxt_word_d = fifo_rd_data;
          end
        end else if (w_take) begin
          w_cur_word_d = fifo_rd_data;
          w_cur_v_d    = 1'b1;
        end else begin
          w_cur_v_d    = 1'b0;
        end
      end else if (w_take) begin
        w_nxt_word_d = fifo_rd_data;
        w_nxt_v_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_word   <= '0;
      r_nxt_word   <= '0;
      r_cur_v      <= 1'b0;
      r_nxt_v      <= 1'b0;
      r_beat_idx   <= '0;
      r_pend       <= 1'b0;
      r_flush_drop <= 1'b0;
      r_started    <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_cur_word   <= w_cur_word_d;
      r_nxt_word   <= w_nxt_word_d;
      r_cur_v      <= w_cur_v_d;
      r_nxt_v      <= w_nxt_v_d;
      r_beat_idx   <= w_beat_idx_d;
      r_pend       <= fifo_rd_en;
      r_flush_drop <= flush;
      r_started    <= ~flush & (r_started | w_fire);
      r_underrun   <= r_started & out_ready & ~r_cur_v & ~flush;
    end
  end

endmodule
